// File: rtl/horner_seq_pkg.sv
// Shared types, default parameters and elaboration helpers for the Horner sequencer.
package horner_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_GAP   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam int DEF_NUM_CH    = 32;
   localparam int DEF_BATCH_CH  = 16;
   localparam int DEF_ORDER     = 10;
   localparam int DEF_PIPE_LAT  = 37;
   localparam int DEF_BATCH_GAP = 16;

   // $clog2 that never collapses to a zero-width vector
   function automatic int clog2_min1(input int v);
      return (v <= 1) ? 1 : $clog2(v);
   endfunction

   function automatic bit cfg_ok(input int num_ch, input int batch_ch, input int pipe_lat);
      return (batch_ch >= 1) && (num_ch >= batch_ch) && ((num_ch % batch_ch) == 0) && (pipe_lat >= 1);
   endfunction

   localparam int CH_W    = clog2_min1(DEF_NUM_CH);
   localparam int COEFF_W = clog2_min1(DEF_ORDER + 1);
   localparam int ITER_W  = clog2_min1(DEF_ORDER + 1);
   localparam int SLOT_W  = clog2_min1(DEF_BATCH_CH);
   localparam int BATCH_W = clog2_min1(DEF_NUM_CH / DEF_BATCH_CH);

endpackage

// File: rtl/horner_wb_delay.sv
// Writeback delay line: carries {valid, channel} PIPE_LAT stages, then emits a registered one-hot enable.
module horner_wb_delay
   import horner_seq_pkg::*;
#(
   parameter int NUM_CH   = DEF_NUM_CH,
   parameter int PIPE_LAT = DEF_PIPE_LAT,
   parameter int CH_BITS  = CH_W
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_flush,
   input  logic               i_push,
   input  logic [CH_BITS-1:0] i_push_ch,
   output logic               o_empty,
   output logic [NUM_CH-1:0]  o_en,
   output logic               o_en_any
);

   logic [PIPE_LAT-1:0] r_vld;
   logic [CH_BITS-1:0]  r_ch [PIPE_LAT];
   logic [NUM_CH-1:0]   r_en;
   logic                r_en_any;
   logic [NUM_CH-1:0]   w_dec;
   logic                w_empty;

   // Empty means nothing is left once the tail stage retires on the next edge
   always_comb begin
      w_empty = ~i_push;
      for (int i = 0; i < PIPE_LAT - 1; i++) begin
         w_empty = w_empty & ~r_vld[i];
      end
      for (int i = 0; i < NUM_CH; i++) begin
         w_dec[i] = r_vld[PIPE_LAT-1] && (r_ch[PIPE_LAT-1] == CH_BITS'(i));
      end
   end

   // Shift the delay line and register the decoded enable; flush drops everything in flight
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_vld    <= '0;
         r_en     <= '0;
         r_en_any <= 1'b0;
         for (int i = 0; i < PIPE_LAT; i++) r_ch[i] <= '0;
      end else if (i_flush) begin
         r_vld    <= '0;
         r_en     <= '0;
         r_en_any <= 1'b0;
         for (int i = 0; i < PIPE_LAT; i++) r_ch[i] <= '0;
      end else begin
         r_vld[0] <= i_push;
         r_ch[0]  <= i_push ? i_push_ch : '0;
         for (int i = 1; i < PIPE_LAT; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_ch[i]  <= r_ch[i-1];
         end
         r_en     <= w_dec;
         r_en_any <= r_vld[PIPE_LAT-1];
      end
   end

   assign o_empty  = w_empty;
   assign o_en     = r_en;
   assign o_en_any = r_en_any;

endmodule

// File: rtl/horner_seq_ctrl.sv
// Batched Horner-evaluation scheduler driving a shared pipelined MAC datapath.
// Optional macro HORNER_SEQ_RESTART_EN: srdyi while busy aborts and restarts the job.
module horner_seq_ctrl
   import horner_seq_pkg::*;
#(
   parameter int NUM_CH    = DEF_NUM_CH,
   parameter int BATCH_CH  = DEF_BATCH_CH,
   parameter int ORDER     = DEF_ORDER,
   parameter int PIPE_LAT  = DEF_PIPE_LAT,
   parameter int BATCH_GAP = DEF_BATCH_GAP
) (
   input  logic                                clk,
   input  logic                                GlobalReset_n,
   input  logic                                srdyi,
   output logic                                busy,
   output logic                                issue_valid,
   output logic [clog2_min1(NUM_CH)-1:0]       channel_select,
   output logic [clog2_min1(ORDER+1)-1:0]      coeff_sel,
   output logic                                sum_rst,
   output logic                                sum_en,
   output logic [NUM_CH-1:0]                   enableRegControl,
   output logic                                srdyo
);

   localparam int NB        = NUM_CH / BATCH_CH;
   localparam int L_CH_W    = clog2_min1(NUM_CH);
   localparam int L_ITER_W  = clog2_min1(ORDER + 1);
   localparam int L_SLOT_W  = clog2_min1(BATCH_CH);
   localparam int L_BATCH_W = clog2_min1(NB);
   localparam int L_GAP_W   = clog2_min1(BATCH_GAP);

   localparam logic [L_SLOT_W-1:0]  SLOT_LAST  = L_SLOT_W'(BATCH_CH - 1);
   localparam logic [L_ITER_W-1:0]  ITER_LAST  = L_ITER_W'(ORDER);
   localparam logic [L_BATCH_W-1:0] BATCH_LAST = L_BATCH_W'(NB - 1);
   localparam logic [L_GAP_W-1:0]   GAP_LAST   = L_GAP_W'(BATCH_GAP - 1);

   if (!cfg_ok(NUM_CH, BATCH_CH, PIPE_LAT)) begin : g_cfg_err
      $error("horner_seq_ctrl: NUM_CH must be a multiple of BATCH_CH and PIPE_LAT >= 1");
   end

   state_t                 r_state;
   logic [L_SLOT_W-1:0]    r_slot;
   logic [L_ITER_W-1:0]    r_iter;
   logic [L_BATCH_W-1:0]   r_batch;
   logic [L_GAP_W-1:0]     r_gap;
   logic                   r_busy;
   logic                   r_issue_valid;
   logic [L_CH_W-1:0]      r_ch_sel;
   logic [L_ITER_W-1:0]    r_coeff_sel;
   logic                   r_sum_rst;
   logic                   r_srdyo;

   logic                   w_idle;
   logic                   w_abort;
   logic                   w_start;
   logic                   w_issue;
   logic                   w_push;
   logic                   w_first;
   logic                   w_empty;
   logic [L_CH_W-1:0]      w_chan;
   logic [L_ITER_W-1:0]    w_coeff;
   logic [NUM_CH-1:0]      w_en;
   logic                   w_en_any;

   // Accept/abort decode plus the channel, coefficient and writeback push of the current slot
   always_comb begin
      w_idle  = (r_state == ST_IDLE) || (r_state == ST_DONE);
`ifdef HORNER_SEQ_RESTART_EN
      w_abort = srdyi && !w_idle;
`else
      w_abort = 1'b0;
`endif
      w_start = srdyi && (w_idle || w_abort);
      w_issue = (r_state == ST_ISSUE) && !w_abort;
      w_push  = w_issue && (r_iter == ITER_LAST);
      w_first = w_issue && (r_batch == '0) && (r_iter == '0) && (r_slot == '0);
      w_chan  = L_CH_W'(L_CH_W'(r_batch) * L_CH_W'(BATCH_CH)) + L_CH_W'(r_slot);
      w_coeff = ITER_LAST - r_iter;
   end

   // Sequencer FSM; outputs are registered from the state held before each edge
   always_ff @(posedge clk or negedge GlobalReset_n) begin
      if (!GlobalReset_n) begin
         r_state       <= ST_IDLE;
         r_slot        <= '0;
         r_iter        <= '0;
         r_batch       <= '0;
         r_gap         <= '0;
         r_busy        <= 1'b0;
         r_issue_valid <= 1'b0;
         r_ch_sel      <= '0;
         r_coeff_sel   <= '0;
         r_sum_rst     <= 1'b0;
         r_srdyo       <= 1'b0;
      end else begin
         r_busy        <= (r_state == ST_ISSUE) || (r_state == ST_GAP) || (r_state == ST_DRAIN);
         r_issue_valid <= w_issue;
         r_ch_sel      <= w_issue ? w_chan : '0;
         r_coeff_sel   <= w_issue ? w_coeff : '0;
         r_sum_rst     <= w_first;
         r_srdyo       <= (r_state == ST_DONE);

         if (w_start) begin
            r_state <= ST_ISSUE;
            r_slot  <= '0;
            r_iter  <= '0;
            r_batch <= '0;
            r_gap   <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_state <= ST_IDLE;
               end
               ST_ISSUE: begin
                  if (r_slot == SLOT_LAST) begin
                     r_slot <= '0;
                     if (r_iter == ITER_LAST) begin
                        r_iter <= '0;
                        if (r_batch == BATCH_LAST) begin
                           r_batch <= '0;
                           r_state <= ST_DRAIN;
                        end else begin
                           r_batch <= r_batch + L_BATCH_W'(1);
                           r_state <= (BATCH_GAP == 0) ? ST_ISSUE : ST_GAP;
                        end
                     end else begin
                        r_iter <= r_iter + L_ITER_W'(1);
                     end
                  end else begin
                     r_slot <= r_slot + L_SLOT_W'(1);
                  end
               end
               ST_GAP: begin
                  if (r_gap == GAP_LAST) begin
                     r_gap   <= '0;
                     r_state <= ST_ISSUE;
                  end else begin
                     r_gap <= r_gap + L_GAP_W'(1);
                  end
               end
               ST_DRAIN: begin
                  if (w_empty) r_state <= ST_DONE;
               end
               ST_DONE: begin
                  r_state <= ST_IDLE;
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   horner_wb_delay #(
      .NUM_CH   (NUM_CH),
      .PIPE_LAT (PIPE_LAT),
      .CH_BITS  (L_CH_W)
   ) u_wb_delay (
      .i_clk     (clk),
      .i_rst_n   (GlobalReset_n),
      .i_flush   (w_abort),
      .i_push    (w_push),
      .i_push_ch (w_chan),
      .o_empty   (w_empty),
      .o_en      (w_en),
      .o_en_any  (w_en_any)
   );

   assign busy             = r_busy;
   assign issue_valid      = r_issue_valid;
   assign channel_select   = r_ch_sel;
   assign coeff_sel        = r_coeff_sel;
   assign sum_rst          = r_sum_rst;
   assign sum_en           = w_en_any;
   assign enableRegControl = w_en;
   assign srdyo            = r_srdyo;

endmodule

// File: tb/tb_horner_seq_ctrl.sv
// Directed bench for horner_seq_ctrl: default configuration plus a small 8/4/2/3/0 instance.
module tb_horner_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        srdyi;
   logic        srdyi_s;

   logic        busy, iv, sum_rst, sum_en, srdyo;
   logic [4:0]  ch;
   logic [3:0]  co;
   logic [31:0] en;

   logic        s_busy, s_iv, s_sum_rst, s_sum_en, s_srdyo;
   logic [2:0]  s_ch;
   logic [1:0]  s_co;
   logic [7:0]  s_en;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          cyc;
      int          sm;
      int          iv;
      int          ch;
      int          co;
      logic [31:0] en;
      int          busy;
      int          srdyo;
      int          srst;
   } vec_t;

   vec_t tbl[$];

   always #5 clk = ~clk;

   horner_seq_ctrl u_dut (
      .clk              (clk),
      .GlobalReset_n    (rst_n),
      .srdyi            (srdyi),
      .busy             (busy),
      .issue_valid      (iv),
      .channel_select   (ch),
      .coeff_sel        (co),
      .sum_rst          (sum_rst),
      .sum_en           (sum_en),
      .enableRegControl (en),
      .srdyo            (srdyo)
   );

   horner_seq_ctrl #(
      .NUM_CH(8), .BATCH_CH(4), .ORDER(2), .PIPE_LAT(3), .BATCH_GAP(0)
   ) u_small (
      .clk              (clk),
      .GlobalReset_n    (rst_n),
      .srdyi            (srdyi_s),
      .busy             (s_busy),
      .issue_valid      (s_iv),
      .channel_select   (s_ch),
      .coeff_sel        (s_co),
      .sum_rst          (s_sum_rst),
      .sum_en           (s_sum_en),
      .enableRegControl (s_en),
      .srdyo            (s_srdyo)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   task automatic add(input int cyc, input int sm, input int v_iv, input int v_ch, input int v_co,
                      input logic [31:0] v_en, input int v_busy, input int v_srdyo, input int v_srst);
      vec_t v;
      v.cyc = cyc; v.sm = sm; v.iv = v_iv; v.ch = v_ch; v.co = v_co;
      v.en = v_en; v.busy = v_busy; v.srdyo = v_srdyo; v.srst = v_srst;
      tbl.push_back(v);
   endtask

   task automatic check_vec(input vec_t v, input string tag);
      int a_iv, a_ch, a_co, a_busy, a_srdyo, a_srst, a_sen, e_sen;
      logic [31:0] a_en;
      if (v.sm != 0) begin
         a_iv = int'(s_iv); a_ch = int'(s_ch); a_co = int'(s_co); a_en = {24'd0, s_en};
         a_busy = int'(s_busy); a_srdyo = int'(s_srdyo); a_srst = int'(s_sum_rst); a_sen = int'(s_sum_en);
      end else begin
         a_iv = int'(iv); a_ch = int'(ch); a_co = int'(co); a_en = en;
         a_busy = int'(busy); a_srdyo = int'(srdyo); a_srst = int'(sum_rst); a_sen = int'(sum_en);
      end
      e_sen = (v.en != 32'd0) ? 1 : 0;
      checks++;
      if (a_iv != v.iv || a_ch != v.ch || a_co != v.co || a_en != v.en || a_busy != v.busy ||
          a_srdyo != v.srdyo || a_srst != v.srst || a_sen != e_sen) begin
         errors++;
         $display("FAIL %s%s@%0d: got iv=%0d ch=%0d co=%0d en=%h busy=%0d srdyo=%0d sum_rst=%0d sum_en=%0d; want iv=%0d ch=%0d co=%0d en=%h busy=%0d srdyo=%0d sum_rst=%0d sum_en=%0d",
                  tag, (v.sm != 0) ? "_small" : "", v.cyc, a_iv, a_ch, a_co, a_en, a_busy, a_srdyo, a_srst, a_sen,
                  v.iv, v.ch, v.co, v.en, v.busy, v.srdyo, v.srst, e_sen);
      end
   endtask

   // One default job from a single srdyi pulse, walked cycle by cycle against the table
   task automatic run_default_job(input string tag, input bit with_small);
      int en_cnt = 0, bad_hot = 0, bad_sen = 0, srdyo_cnt = 0, srdyo_at = -1;
      int busy_cnt = 0, iss_cnt = 0, gap_bad = 0, first_en = -1;
      srdyi = 1'b1;
      srdyi_s = with_small;
      step();
      srdyi = 1'b0;
      srdyi_s = 1'b0;
      for (int c = 0; c <= 410; c++) begin
         if (c > 0) step();
         foreach (tbl[i]) begin
            if (tbl[i].cyc == c && (with_small || tbl[i].sm == 0)) check_vec(tbl[i], tag);
         end
         if (en != 32'd0) begin
            en_cnt++;
            if (first_en < 0) first_en = c;
         end
         if ($countones(en) > 1) bad_hot++;
         if (sum_en != (en != 32'd0)) bad_sen++;
         if (srdyo) begin srdyo_cnt++; srdyo_at = c; end
         if (busy) busy_cnt++;
         if (iv) iss_cnt++;
         if (c >= 177 && c <= 192 && (iv || ch != 5'd0)) gap_bad++;
      end
      chk({tag, "_en_cycles"}, en_cnt, 32);
      chk({tag, "_first_en"}, first_en, 198);
      chk({tag, "_multi_hot"}, bad_hot, 0);
      chk({tag, "_sum_en"}, bad_sen, 0);
      chk({tag, "_srdyo_cnt"}, srdyo_cnt, 1);
      chk({tag, "_srdyo_at"}, srdyo_at, 406);
      chk({tag, "_busy_cycles"}, busy_cnt, 405);
      chk({tag, "_issue_cycles"}, iss_cnt, 352);
      chk({tag, "_gap_idle"}, gap_bad, 0);
   endtask

   // Second srdyi pulse at cycle 100 of a running job
   task automatic run_busy_pulse();
      int first_en = -1, srdyo_at = -1, srdyo_cnt = 0, en_cnt = 0;
      int e_first, e_srdyo, e_ch101, e_co101;
`ifdef HORNER_SEQ_RESTART_EN
      e_first = 298; e_srdyo = 506; e_ch101 = 0; e_co101 = 10;
`else
      e_first = 198; e_srdyo = 406; e_ch101 = 4; e_co101 = 4;
`endif
      srdyi = 1'b1;
      step();
      srdyi = 1'b0;
      for (int c = 1; c <= 520; c++) begin
         step();
         if (en != 32'd0) begin
            en_cnt++;
            if (first_en < 0) first_en = c;
         end
         if (srdyo) begin srdyo_cnt++; srdyo_at = c; end
         if (c == 101) begin
            chk("pulse_iv101", int'(iv), 1);
            chk("pulse_ch101", int'(ch), e_ch101);
            chk("pulse_co101", int'(co), e_co101);
         end
         srdyi = (c == 99);
      end
      chk("pulse_first_en", first_en, e_first);
      chk("pulse_en_cycles", en_cnt, 32);
      chk("pulse_srdyo_cnt", srdyo_cnt, 1);
      chk("pulse_srdyo_at", srdyo_at, e_srdyo);
   endtask

   // Asynchronous reset in the middle of a job
   task automatic run_mid_reset();
      int late_en = 0, late_busy = 0;
      srdyi = 1'b1;
      step();
      srdyi = 1'b0;
      for (int c = 1; c <= 200; c++) step();
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", int'(|{busy, iv, ch, co, sum_rst, sum_en, en, srdyo}), 0);
      step();
      #2 rst_n = 1'b1;
      for (int c = 0; c < 300; c++) begin
         step();
         if (en != 32'd0) late_en++;
         if (busy) late_busy++;
      end
      chk("reset_no_enables", late_en, 0);
      chk("reset_idle", late_busy, 0);
      run_default_job("after_reset", 1'b0);
   endtask

   // Back-to-back jobs with srdyi accepted in the DONE cycle
   task automatic run_back_to_back();
      int srdyo_cnt = 0, srdyo_1st = -1, srdyo_2nd = -1;
      srdyi = 1'b1;
      step();
`ifdef HORNER_SEQ_RESTART_EN
      srdyi = 1'b0;
`endif
      for (int c = 1; c <= 815; c++) begin
         step();
         if (srdyo) begin
            srdyo_cnt++;
            if (srdyo_1st < 0) srdyo_1st = c;
            else srdyo_2nd = c;
         end
         if (c == 406) chk("b2b_iv406", int'(iv), 0);
         if (c == 407) begin
            chk("b2b_iv407", int'(iv), 1);
            chk("b2b_ch407", int'(ch), 0);
            chk("b2b_co407", int'(co), 10);
            chk("b2b_busy407", int'(busy), 1);
         end
         if (c == 814) chk("b2b_idle814", int'(busy), 0);
`ifdef HORNER_SEQ_RESTART_EN
         srdyi = (c == 405);
`else
         srdyi = (c < 811);
`endif
      end
      srdyi = 1'b0;
      chk("b2b_srdyo_cnt", srdyo_cnt, 2);
      chk("b2b_srdyo_1st", srdyo_1st, 406);
      chk("b2b_srdyo_2nd", srdyo_2nd, 812);
   endtask

   initial begin
      rst_n   = 1'b0;
      srdyi   = 1'b0;
      srdyi_s = 1'b0;

      add(0,   0, 0, 0,  0,  32'h0,         0, 0, 0);
      add(1,   0, 1, 0,  10, 32'h0,         1, 0, 1);
      add(2,   0, 1, 1,  10, 32'h0,         1, 0, 0);
      add(16,  0, 1, 15, 10, 32'h0,         1, 0, 0);
      add(17,  0, 1, 0,  9,  32'h0,         1, 0, 0);
      add(161, 0, 1, 0,  0,  32'h0,         1, 0, 0);
      add(176, 0, 1, 15, 0,  32'h0,         1, 0, 0);
      add(177, 0, 0, 0,  0,  32'h0,         1, 0, 0);
      add(192, 0, 0, 0,  0,  32'h0,         1, 0, 0);
      add(193, 0, 1, 16, 10, 32'h0,         1, 0, 0);
      add(197, 0, 1, 20, 10, 32'h0,         1, 0, 0);
      add(198, 0, 1, 21, 10, 32'h1,         1, 0, 0);
      add(213, 0, 1, 20, 9,  32'h8000,      1, 0, 0);
      add(214, 0, 1, 21, 9,  32'h0,         1, 0, 0);
      add(368, 0, 1, 31, 0,  32'h0,         1, 0, 0);
      add(369, 0, 0, 0,  0,  32'h0,         1, 0, 0);
      add(390, 0, 0, 0,  0,  32'h10000,     1, 0, 0);
      add(405, 0, 0, 0,  0,  32'h8000_0000, 1, 0, 0);
      add(406, 0, 0, 0,  0,  32'h0,         0, 1, 0);
      add(407, 0, 0, 0,  0,  32'h0,         0, 0, 0);
      add(0,   1, 0, 0,  0,  32'h0,         0, 0, 0);
      add(1,   1, 1, 0,  2,  32'h0,         1, 0, 1);
      add(9,   1, 1, 0,  0,  32'h0,         1, 0, 0);
      add(12,  1, 1, 3,  0,  32'h1,         1, 0, 0);
      add(13,  1, 1, 4,  2,  32'h2,         1, 0, 0);
      add(24,  1, 1, 7,  0,  32'h10,        1, 0, 0);
      add(25,  1, 0, 0,  0,  32'h20,        1, 0, 0);
      add(27,  1, 0, 0,  0,  32'h80,        1, 0, 0);
      add(28,  1, 0, 0,  0,  32'h0,         0, 1, 0);

      repeat (3) @(posedge clk);
      #1;
      chk("reset_state_big", int'(|{busy, iv, ch, co, sum_rst, sum_en, en, srdyo}), 0);
      chk("reset_state_small", int'(|{s_busy, s_iv, s_ch, s_co, s_sum_rst, s_sum_en, s_en, s_srdyo}), 0);
      #3 rst_n = 1'b1;
      step();

      run_default_job("single", 1'b1);
      repeat (5) step();
      run_busy_pulse();
      repeat (5) step();
      run_mid_reset();
      repeat (5) step();
      run_back_to_back();
      repeat (3) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
